// File: rtl/cmd_pkg.sv
// Shared types and helpers for the command serializer.
// Optional odd-parity bit enabled by CMD_SERIALIZER_PARITY_EN.
package cmd_pkg;

  localparam int unsigned CMD_W = 16;

`ifdef CMD_SERIALIZER_PARITY_EN
  localparam int unsigned N_BITS = CMD_W + 1;
`else
  localparam int unsigned N_BITS = CMD_W;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_e;

  // Bit that makes the total count of ones over {word, bit} odd.
  function automatic logic odd_parity(input logic [CMD_W-1:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/cmd_serializer_sclk_tick.sv
// Half-period tick generator for SCLK; counter held at zero while disabled
// so every entry into the shift phase starts a fresh half-period.
module sclk_tick
  import cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    tick_c = 1'b0;
    if (en) begin
      tick_c = (cnt_q == CNT_LAST);
      cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_serializer.sv
// Serializes a 16-bit command MSB first over CS_N/SCLK/SDATA.
// Define CMD_SERIALIZER_PARITY_EN to append an odd-parity bit after CMD[0].
module cmd_serializer
  import cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TX_START,
  input  logic [CMD_W-1:0]  CMD,
  output logic              TX_END,
  output logic              BUSY,
  output logic              CS_N,
  output logic              SCLK,
  output logic              SDATA
);

  localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned BIT_W  = $clog2(N_BITS);
  localparam int unsigned SH_W   = N_BITS - 1;

  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N_BITS - 1);

  state_e           state_q, state_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             cs_n_q, cs_n_d;
  logic             tx_end_q, tx_end_d;
  logic             busy_q, busy_d;
  logic             tick_c;

  sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .en     (state_q == SHIFT),
    .tick_c (tick_c)
  );

  // Shift register holds the bits still to be sent after the one on SDATA.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    cs_n_d   = cs_n_q;
    tx_end_d = 1'b0;
    busy_d   = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (TX_START) begin
`ifdef CMD_SERIALIZER_PARITY_EN
          shift_d = {CMD[CMD_W-2:0], odd_parity(CMD)};
`else
          shift_d = CMD[CMD_W-2:0];
`endif
          sdata_d = CMD[CMD_W-1];
          cs_n_d  = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          ph_d    = '0;
          state_d = SHIFT;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      // Data advances only on the falling SCLK edge.
      SHIFT: begin
        if (tick_c) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              sdata_d = shift_q[SH_W-1];
              shift_d = shift_q << 1;
            end
          end
        end
      end

      HOLD: begin
        if (ph_q == HOLD_LAST) begin
          ph_d    = '0;
          cs_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      DONE: begin
        tx_end_d = 1'b1;
        sdata_d  = 1'b0;
        shift_d  = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      ph_q     <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      tx_end_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      cs_n_q   <= cs_n_d;
      tx_end_q <= tx_end_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_END = tx_end_q;
  assign BUSY   = busy_q;
  assign CS_N   = cs_n_q;
  assign SCLK   = sclk_q;
  assign SDATA  = sdata_q;

endmodule

// File: tb/tb_cmd_serializer.sv
// Directed bench for cmd_serializer: default-timing instance and a fast
// CLK_DIV=1/CS_SETUP=1/CS_HOLD=1 instance; follows CMD_SERIALIZER_PARITY_EN.
module tb_cmd_serializer;

`ifdef CMD_SERIALIZER_PARITY_EN
  localparam int NB = 17;
  localparam logic [NB-1:0] W_8A55 = {16'h8A55, 1'b0};
  localparam logic [NB-1:0] W_3C96 = {16'h3C96, 1'b1};
  localparam logic [NB-1:0] W_0000 = {16'h0000, 1'b1};
  localparam logic [NB-1:0] W_0001 = {16'h0001, 1'b0};
  localparam logic [NB-1:0] W_FFFF = {16'hFFFF, 1'b1};
`else
  localparam int NB = 16;
  localparam logic [NB-1:0] W_8A55 = 16'h8A55;
  localparam logic [NB-1:0] W_3C96 = 16'h3C96;
  localparam logic [NB-1:0] W_0000 = 16'h0000;
  localparam logic [NB-1:0] W_0001 = 16'h0001;
  localparam logic [NB-1:0] W_FFFF = 16'hFFFF;
`endif
  localparam int T0 = NB * 8 + 5;   // defaults: 133 (141 with parity)
  localparam int T1 = NB * 2 + 3;   // fast instance: 35 (37 with parity)

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  tx_start = 2'b00;
  logic [15:0] cmd0 = 16'h0000;
  logic [15:0] cmd1 = 16'h0000;
  logic [1:0]  tx_end, busy, cs_n, sclk, sdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] o_bits;
  int          o_rise, o_tend_cyc, o_tend2_cyc, o_tend_cnt, o_busy_cnt, o_csn_falls, o_gap;
  logic [3:0]  o_snap;

  always #5 CLK = ~CLK;

  cmd_serializer dut0 (
    .CLK(CLK), .RST(RST), .TX_START(tx_start[0]), .CMD(cmd0),
    .TX_END(tx_end[0]), .BUSY(busy[0]), .CS_N(cs_n[0]), .SCLK(sclk[0]), .SDATA(sdata[0])
  );

  cmd_serializer #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut1 (
    .CLK(CLK), .RST(RST), .TX_START(tx_start[1]), .CMD(cmd1),
    .TX_END(tx_end[1]), .BUSY(busy[1]), .CS_N(cs_n[1]), .SCLK(sclk[1]), .SDATA(sdata[1])
  );

  task automatic set_in(input int which, input logic s, input logic [15:0] c);
    if (which == 0) begin
      tx_start[0] = s;
      cmd0        = c;
    end else begin
      tx_start[1] = s;
      cmd1        = c;
    end
  endtask

  // Launches one word (accepted on the next edge = cycle 0) and records what
  // the outputs do for ncyc cycles; optional second start and reset pulse.
  task automatic run_txn(input int which, input logic [15:0] c1, input logic [15:0] c2,
                         input int start2_at, input int rst_at, input int ncyc);
    logic p_sclk, p_csn, s_sclk, s_csn;
    int   hi_run;
    o_bits = '0; o_rise = 0; o_tend_cyc = -1; o_tend2_cyc = -1; o_tend_cnt = 0;
    o_busy_cnt = 0; o_csn_falls = 0; o_gap = -1; o_snap = '0;
    p_sclk = 1'b0; p_csn = 1'b1; hi_run = 0;
    set_in(which, 1'b1, c1);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge CLK);
      #1;
      if (c == 0 || c == start2_at + 1) set_in(which, 1'b0, ~c1);
      if (c == start2_at) set_in(which, 1'b1, c2);
      if (c == rst_at) RST = 1'b0;
      if (c == rst_at + 1) RST = 1'b1;
      s_sclk = sclk[which];
      s_csn  = cs_n[which];
      if (s_sclk && !p_sclk) begin
        o_bits = {o_bits[62:0], sdata[which]};
        o_rise++;
      end
      if (tx_end[which]) begin
        if (o_tend_cnt == 0) o_tend_cyc = c;
        else if (o_tend_cnt == 1) o_tend2_cyc = c;
        o_tend_cnt++;
      end
      if (busy[which]) o_busy_cnt++;
      if (s_csn) begin
        hi_run++;
      end else if (p_csn) begin
        o_csn_falls++;
        if (o_csn_falls == 2) o_gap = hi_run;
        hi_run = 0;
      end
      if (c == rst_at + 1) o_snap = {s_csn, s_sclk, sdata[which], busy[which]};
      p_sclk = s_sclk;
      p_csn  = s_csn;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (cs_n[i] !== 1'b1) begin errors++; $display("FAIL reset_cs_n[%0d] got %b exp 1", i, cs_n[i]); end
      checks++; if (sclk[i] !== 1'b0) begin errors++; $display("FAIL reset_sclk[%0d] got %b exp 0", i, sclk[i]); end
      checks++; if (sdata[i] !== 1'b0) begin errors++; $display("FAIL reset_sdata[%0d] got %b exp 0", i, sdata[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", i, busy[i]); end
      checks++; if (tx_end[i] !== 1'b0) begin errors++; $display("FAIL reset_tx_end[%0d] got %b exp 0", i, tx_end[i]); end
    end
  endtask

  // Release reset and start in the same cycle: first edge with RST=1 accepts.
  task automatic test_basic();
    RST = 1'b1;
    run_txn(0, 16'h8A55, 16'h0000, -10, -10, T0 + 10);
    checks++; if (o_bits[NB-1:0] !== W_8A55) begin errors++; $display("FAIL basic_bits got %h exp %h", o_bits[NB-1:0], W_8A55); end
    checks++; if (o_rise != NB) begin errors++; $display("FAIL basic_rises got %0d exp %0d", o_rise, NB); end
    checks++; if (o_tend_cyc != T0) begin errors++; $display("FAIL basic_tx_end_cycle got %0d exp %0d", o_tend_cyc, T0); end
    checks++; if (o_tend_cnt != 1) begin errors++; $display("FAIL basic_tx_end_count got %0d exp 1", o_tend_cnt); end
    checks++; if (o_busy_cnt != T0) begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", o_busy_cnt, T0); end
    checks++; if (o_csn_falls != 1) begin errors++; $display("FAIL basic_cs_n_falls got %0d exp 1", o_csn_falls); end
    checks++; if (sdata[0] !== 1'b0) begin errors++; $display("FAIL basic_sdata_idle got %b exp 0", sdata[0]); end
  endtask

  task automatic test_patterns();
    run_txn(0, 16'h0000, 16'h0000, -10, -10, T0 + 5);
    checks++; if (o_bits[NB-1:0] !== W_0000) begin errors++; $display("FAIL pat0000_bits got %h exp %h", o_bits[NB-1:0], W_0000); end
    checks++; if (o_tend_cyc != T0) begin errors++; $display("FAIL pat0000_tx_end_cycle got %0d exp %0d", o_tend_cyc, T0); end
    run_txn(0, 16'h0001, 16'h0000, -10, -10, T0 + 5);
    checks++; if (o_bits[NB-1:0] !== W_0001) begin errors++; $display("FAIL pat0001_bits got %h exp %h", o_bits[NB-1:0], W_0001); end
    checks++; if (o_rise != NB) begin errors++; $display("FAIL pat0001_rises got %0d exp %0d", o_rise, NB); end
  endtask

  task automatic test_ignore();
    run_txn(0, 16'h8A55, 16'h3C96, 50, -10, T0 + 40);
    checks++; if (o_tend_cnt != 1) begin errors++; $display("FAIL ign_mid_tx_end_count got %0d exp 1", o_tend_cnt); end
    checks++; if (o_csn_falls != 1) begin errors++; $display("FAIL ign_mid_cs_n_falls got %0d exp 1", o_csn_falls); end
    checks++; if (o_bits[NB-1:0] !== W_8A55) begin errors++; $display("FAIL ign_mid_bits got %h exp %h", o_bits[NB-1:0], W_8A55); end
    checks++; if (o_tend_cyc != T0) begin errors++; $display("FAIL ign_mid_tx_end_cycle got %0d exp %0d", o_tend_cyc, T0); end
    // Start held during the DONE cycle (sampled while still in DONE).
    run_txn(0, 16'h8A55, 16'h3C96, T0 - 1, -10, 2 * T0 + 10);
    checks++; if (o_tend_cnt != 1) begin errors++; $display("FAIL ign_done_tx_end_count got %0d exp 1", o_tend_cnt); end
    checks++; if (o_csn_falls != 1) begin errors++; $display("FAIL ign_done_cs_n_falls got %0d exp 1", o_csn_falls); end
  endtask

  task automatic test_reset_mid();
    run_txn(0, 16'h8A55, 16'h0000, -10, 40, T0 + 10);
    checks++; if (o_snap !== 4'b1000) begin errors++; $display("FAIL rstmid_snapshot {cs_n,sclk,sdata,busy} got %b exp 1000", o_snap); end
    checks++; if (o_tend_cnt != 0) begin errors++; $display("FAIL rstmid_tx_end_count got %0d exp 0", o_tend_cnt); end
    run_txn(0, 16'h3C96, 16'h0000, -10, -10, T0 + 5);
    checks++; if (o_bits[NB-1:0] !== W_3C96) begin errors++; $display("FAIL rstmid_after_bits got %h exp %h", o_bits[NB-1:0], W_3C96); end
    checks++; if (o_tend_cyc != T0) begin errors++; $display("FAIL rstmid_after_tx_end_cycle got %0d exp %0d", o_tend_cyc, T0); end
  endtask

  task automatic test_fast();
    run_txn(1, 16'hFFFF, 16'h0000, -10, -10, T1 + 10);
    checks++; if (o_rise != NB) begin errors++; $display("FAIL fast_rises got %0d exp %0d", o_rise, NB); end
    checks++; if (o_bits[NB-1:0] !== W_FFFF) begin errors++; $display("FAIL fast_bits got %h exp %h", o_bits[NB-1:0], W_FFFF); end
    checks++; if (o_tend_cyc != T1) begin errors++; $display("FAIL fast_tx_end_cycle got %0d exp %0d", o_tend_cyc, T1); end
    checks++; if (o_busy_cnt != T1) begin errors++; $display("FAIL fast_busy_cycles got %0d exp %0d", o_busy_cnt, T1); end
  endtask

  // Second start held during the TX_END cycle is sampled back in IDLE.
  task automatic test_back_to_back();
    run_txn(0, 16'h8A55, 16'h3C96, T0, -10, 2 * T0 + 10);
    checks++; if (o_tend_cnt != 2) begin errors++; $display("FAIL b2b_tx_end_count got %0d exp 2", o_tend_cnt); end
    checks++; if (o_tend2_cyc != 2 * T0 + 1) begin errors++; $display("FAIL b2b_second_tx_end_cycle got %0d exp %0d", o_tend2_cyc, 2 * T0 + 1); end
    checks++; if (o_gap < 1) begin errors++; $display("FAIL b2b_cs_n_gap got %0d exp >=1", o_gap); end
    checks++; if (o_rise != 2 * NB) begin errors++; $display("FAIL b2b_rises got %0d exp %0d", o_rise, 2 * NB); end
    checks++; if (o_bits[2*NB-1:0] !== {W_8A55, W_3C96}) begin errors++; $display("FAIL b2b_bits got %h exp %h", o_bits[2*NB-1:0], {W_8A55, W_3C96}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_ignore();
    test_reset_mid();
    test_fast();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_serializer.md
CMD_SERIALIZER -- requirements
Module: cmd_serializer

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, meaning CLK cycles per SCLK half-period (legal ≥1).
REQ-002 SHALL provide parameter CS_SETUP, default 2, meaning CLK cycles from CS_N fall to first SCLK activity (legal ≥1).
REQ-003 SHALL provide parameter CS_HOLD, default 2, meaning CLK cycles from last SCLK fall to CS_N rise (legal ≥1).
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 TX_START  input  1  one-cycle request; CMD is valid in the same cycle.
REQ-007 CMD  input  16  command word, {MODE, payload}, sent MSB first.
REQ-008 TX_END  output  1  one-cycle pulse on transaction completion.
REQ-009 BUSY  output  1  high from the cycle after TX_START acceptance until the TX_END cycle inclusive.
REQ-010 CS_N  output  1  serial chip select, active-low.
REQ-011 SCLK  output  1  serial clock, idle low.
REQ-012 SDATA  output  1  serial data, changes only while SCLK low.

Function
REQ-013 SHALL implement states IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-014 IDLE: TX_START=1 sampled -> latch CMD into shift register, CS_N<=0, SDATA<=CMD[15], go SETUP; TX_START=0 -> stay.
REQ-015 SETUP: hold SCLK=0 for CS_SETUP cycles, then go SHIFT.
REQ-016 SHIFT: each bit = CLK_DIV cycles SCLK=0 followed by CLK_DIV cycles SCLK=1; SDATA advances to next bit on the cycle SCLK falls.
REQ-017 After N_BITS rising SCLK edges (N_BITS=16, or 17 per REQ-027) and the final falling edge, SHALL go HOLD.
REQ-018 HOLD: SCLK=0, CS_N=0 for CS_HOLD cycles, then CS_N<=1, go DONE.
REQ-019 DONE: TX_END=1 for exactly one cycle, SDATA<=0, go IDLE.
REQ-020 TX_END SHALL assert N_BITS*2*CLK_DIV + CS_SETUP + CS_HOLD + 1 cycles after the TX_START sampling edge (defaults: 133).
REQ-021 TX_START while not in IDLE SHALL be ignored; latched word SHALL not change mid-transaction.
REQ-022 TX_START in the DONE cycle SHALL be ignored; acceptance only from IDLE.
REQ-023 CMD changes after acceptance SHALL have no effect on SDATA.
REQ-024 Counters SHALL be sized by $clog2 of their maximum parameter-derived value; no wrap-around within a transaction.

Reset
REQ-025 RST=0 at any rising edge SHALL force IDLE, CS_N=1, SCLK=0, SDATA=0, TX_END=0, BUSY=0, shift register and counters 0, including mid-transaction (no TX_END produced for the aborted word).
REQ-026 First TX_START SHALL be accepted on the first edge with RST=1.

Configuration
REQ-027 With macro CMD_SERIALIZER_PARITY_EN defined, SHALL append one odd-parity bit (XNOR-reduction of CMD, so total ones over 17 bits odd) after CMD[0], N_BITS=17; without it, N_BITS=16 and no extra bit.

Structure
REQ-028 Package cmd_pkg SHALL hold CMD_W=16, the state enum, and the odd-parity function.
REQ-029 Sub-module sclk_tick SHALL generate the CLK_DIV half-period tick, enabled only in SHIFT and cleared on state entry.

Verification
REQ-030 Reset, then TX_START with CMD=16'h8A55, defaults -> SDATA bits 1000_1010_0101_0101 sampled on SCLK rising edges, TX_END at cycle 133, BUSY high 133 cycles.
REQ-031 CMD=16'h0000 with CMD_SERIALIZER_PARITY_EN -> 17 bits, last bit 1, TX_END at cycle 141; CMD=16'h0001 -> last bit 0.
REQ-032 Second TX_START at cycle 50 of a transaction -> ignored, only one TX_END, CS_N single low pulse.
REQ-033 RST=0 at cycle 40 of a transaction -> next cycle CS_N=1, SCLK=0, SDATA=0, BUSY=0, no TX_END; new TX_START after release completes normally.
REQ-034 CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CMD=16'hFFFF -> SCLK toggles every cycle, 16 rising edges with SDATA=1, TX_END at cycle 35.
REQ-035 Back-to-back: TX_START asserted in the cycle after TX_END -> accepted, CS_N high for ≥1 cycle between words.
